// File: rtl/safe_code_sender.sv
// -----------------------------------------------------------------------------
// safe_code_sender
//
// Upstream driver for the safe's byte-entry port.
//
// It takes a whole code word over a valid/ready handshake. It then sends that
// word MSB-first, one byte per cycle, on din/din_valid. GAP idle cycles can be
// placed between consecutive bytes. After the last byte it watches the safe's
// unlocked flag for up to TIMEOUT cycles. It then gives a one-cycle done pulse
// together with a pass/fail result on success.
//
// Parameters:
//   NBYTES  - bytes per code; the code is 8*NBYTES bits wide
//   GAP     - idle cycles between consecutive bytes (0 = back-to-back)
//   TIMEOUT - maximum number of WAIT cycles (>= 1)
//
// Ports:
//   clk        in   system clock; all state changes on the rising edge
//   reset      in   synchronous, active-high reset
//   code_in    in   code word; byte NBYTES-1 is sent first
//   code_valid in   code_in is valid
//   code_ready out  high only in IDLE; the block can accept a code
//   din        out  current code byte; 0 when din_valid is low
//   din_valid  out  din carries a byte this cycle
//   unlocked   in   unlock flag from the safe
//   done       out  one-cycle pulse when an attempt finishes
//   success    out  result of the last attempt; held until the next accept
// -----------------------------------------------------------------------------
module safe_code_sender #(
  parameter int NBYTES  = 4,
  parameter int GAP     = 0,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8*NBYTES-1:0] code_in,
  input  logic                code_valid,
  output logic                code_ready,
  output logic [7:0]          din,
  output logic                din_valid,
  input  logic                unlocked,
  output logic                done,
  output logic                success
);

  localparam int W     = 8 * NBYTES;
  localparam int IDX_W = (NBYTES  > 1) ? $clog2(NBYTES)  : 1;
  localparam int GAP_W = (GAP     > 1) ? $clog2(GAP)     : 1;
  localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_GAP,
    S_WAIT,
    S_DONE
  } state_t;

  state_t           state_q;
  // The bytes still to be sent. The next one always sits in the top byte,
  // so each send takes a fixed slice and then shifts left by one byte.
  logic [W-1:0]     code_q;
  logic [IDX_W-1:0] idx_q;
  logic [GAP_W-1:0] gap_q;
  logic [TO_W-1:0]  to_q;
  // Remembers an unlock seen while the bytes were still going out. This
  // covers a safe that opens on the same cycle as the last byte.
  logic             hit_q;

  logic             code_ready_q;
  logic [7:0]       din_q;
  logic             din_valid_q;
  logic             done_q;
  logic             success_q;

  logic             unlock_seen;
  assign unlock_seen = hit_q | unlocked;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      code_q       <= '0;
      idx_q        <= '0;
      gap_q        <= '0;
      to_q         <= '0;
      hit_q        <= 1'b0;
      code_ready_q <= 1'b1;
      din_q        <= 8'h00;
      din_valid_q  <= 1'b0;
      done_q       <= 1'b0;
      success_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (code_valid && code_ready_q) begin
            // The first byte goes out in the cycle right after the handshake.
            din_q        <= code_in[W-1 -: 8];
            din_valid_q  <= 1'b1;
            code_q       <= code_in << 8;
            idx_q        <= '0;
            hit_q        <= 1'b0;
            success_q    <= 1'b0;
            code_ready_q <= 1'b0;
            state_q      <= S_SEND;
          end
        end

        S_SEND: begin
          if (unlocked) begin
            hit_q <= 1'b1;
          end
          if (idx_q == IDX_LAST) begin
            din_q       <= 8'h00;
            din_valid_q <= 1'b0;
            to_q        <= '0;
            state_q     <= S_WAIT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
            if (GAP > 0) begin
              din_q       <= 8'h00;
              din_valid_q <= 1'b0;
              gap_q       <= '0;
              state_q     <= S_GAP;
            end else begin
              din_q  <= code_q[W-1 -: 8];
              code_q <= code_q << 8;
            end
          end
        end

        S_GAP: begin
          if (unlocked) begin
            hit_q <= 1'b1;
          end
          if (gap_q == GAP_LAST) begin
            din_q       <= code_q[W-1 -: 8];
            din_valid_q <= 1'b1;
            code_q      <= code_q << 8;
            state_q     <= S_SEND;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end

        S_WAIT: begin
          // Leave on the first cycle that shows an unlock. Otherwise leave
          // after TIMEOUT cycles with a failed result.
          if (unlock_seen || (to_q == TO_LAST)) begin
            success_q <= unlock_seen;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
        end

        S_DONE: begin
          code_ready_q <= 1'b1;
          state_q      <= S_IDLE;
        end

        default: begin
          code_ready_q <= 1'b1;
          din_q        <= 8'h00;
          din_valid_q  <= 1'b0;
          state_q      <= S_IDLE;
        end
      endcase
    end
  end

  assign code_ready = code_ready_q;
  assign din        = din_q;
  assign din_valid  = din_valid_q;
  assign done       = done_q;
  assign success    = success_q;

endmodule

// File: tb/tb_safe_code_sender.sv
// -----------------------------------------------------------------------------
// tb_safe_code_sender
//
// Drives two senders with NBYTES=4 and TIMEOUT=8: one with GAP=0, one with
// GAP=2. For each attempt the bench computes the expected output trace from
// the timing rules. The rules give the byte slots, the start of the wait
// window, the first unlock that counts, and the done cycle. The bench then
// compares every output on every cycle of the attempt.
// -----------------------------------------------------------------------------
module tb_safe_code_sender;

  localparam int NB = 4;
  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] code_in = '0;
  logic        cv0 = 1'b0;
  logic        cv2 = 1'b0;
  logic        unlocked = 1'b0;

  logic        rdy0, dv0, done0, succ0;
  logic [7:0]  din0;
  logic        rdy2, dv2, done2, succ2;
  logic [7:0]  din2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  safe_code_sender #(.NBYTES(NB), .GAP(0), .TIMEOUT(TO)) dut0 (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(cv0),
    .code_ready(rdy0), .din(din0), .din_valid(dv0), .unlocked(unlocked),
    .done(done0), .success(succ0)
  );

  safe_code_sender #(.NBYTES(NB), .GAP(2), .TIMEOUT(TO)) dut2 (
    .clk(clk), .reset(reset), .code_in(code_in), .code_valid(cv2),
    .code_ready(rdy2), .din(din2), .din_valid(dv2), .unlocked(unlocked),
    .done(done2), .success(succ2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One attempt on the selected sender (0: GAP=0, 1: GAP=2).
  // unl[r] is the unlocked level driven in relative cycle r, where the
  // handshake edge is k and cycle r is the one sampled at edge k+r.
  // With hold set, code_valid stays high throughout, and code_in is
  // scrambled while the attempt runs.
  // The task returns at the start of cycle rd+1, which is IDLE again.
  task automatic run(input int sel, input logic [31:0] code, input logic [63:0] unl,
                     input bit hold);
    int gap, rl, rw, rd, ru;
    logic exp_s, e_dv, o_dv, o_rdy, o_done, o_s;
    logic [7:0] e_din, o_din;
    logic [31:0] c;
    c   = code;
    gap = (sel != 0) ? 2 : 0;
    rl  = 1 + (NB - 1) * (gap + 1);   // last byte cycle
    rw  = rl + 1;                     // first WAIT cycle
    ru  = -1;
    for (int r = 1; r <= rw + TO - 1; r++)
      if (unl[r] && ru < 0) ru = r;
    if (ru < 0) begin
      rd = rw + TO; exp_s = 1'b0;
    end else if (ru < rw) begin
      rd = rw + 1;  exp_s = 1'b1;
    end else begin
      rd = ru + 1;  exp_s = 1'b1;
    end

    code_in = code;
    cv0 = (sel == 0);
    cv2 = (sel != 0);
    @(posedge clk); #1;
    for (int r = 1; r <= rd + 1; r++) begin
      if (sel != 0) begin
        o_dv = dv2; o_din = din2; o_rdy = rdy2; o_done = done2; o_s = succ2;
      end else begin
        o_dv = dv0; o_din = din0; o_rdy = rdy0; o_done = done0; o_s = succ0;
      end
      e_dv  = (r <= rl) && (((r - 1) % (gap + 1)) == 0);
      e_din = e_dv ? c[8 * (NB - 1 - (r - 1) / (gap + 1)) +: 8] : 8'h00;
      check("din_valid",  {31'd0, o_dv},   {31'd0, e_dv});
      check("din",        {24'd0, o_din},  {24'd0, e_din});
      check("code_ready", {31'd0, o_rdy},  {31'd0, (r == rd + 1)});
      check("done",       {31'd0, o_done}, {31'd0, (r == rd)});
      check("success",    {31'd0, o_s},    {31'd0, (r >= rd) ? exp_s : 1'b0});
      unlocked = unl[r];
      if (!hold) begin
        cv0 = 1'b0; cv2 = 1'b0;
      end else if (r <= rd) begin
        code_in = $urandom;
      end
      if (r <= rd) begin
        @(posedge clk); #1;
      end
    end
    $display("attempt sel=%0d code=%08h unl=%016h done@%0d success=%0b", sel, code, unl, rd, exp_s);
  endtask

  initial begin
    logic [63:0] u;
    logic [31:0] c;
    int mode, sel;

    // Reset for two cycles and check the reset values.
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready0", {31'd0, rdy0}, 32'd1);
    check("rst_dv0",    {31'd0, dv0},  32'd0);
    check("rst_din0",   {24'd0, din0}, 32'd0);
    check("rst_done0",  {31'd0, done0}, 32'd0);
    check("rst_succ0",  {31'd0, succ0}, 32'd0);
    check("rst_ready2", {31'd0, rdy2}, 32'd1);
    reset = 1'b0;
    $display("reset done");

    // The safe opens in cycle k+6, so done and success come in k+7.
    run(0, 32'hbaadc0de, 64'd1 << 6, 1'b0);
    // The safe never opens: the timeout gives done in k+13 with success 0.
    run(0, 32'h12345678, 64'd0, 1'b0);
    // GAP=2 byte pattern.
    run(1, 32'h01020304, 64'd0, 1'b0);
    run(1, 32'hdeadbeef, 64'd1 << 10, 1'b0);

    // Reset during the third byte cycle.
    c = 32'hcafef00d;
    code_in = c; cv0 = 1'b1; cv2 = 1'b0; unlocked = 1'b0;
    @(posedge clk); #1;
    cv0 = 1'b0;
    for (int r = 1; r <= 3; r++) begin
      check("abort_dv",  {31'd0, dv0},  32'd1);
      check("abort_din", {24'd0, din0}, {24'd0, c[8 * (NB - r) +: 8]});
      if (r < 3) begin
        @(posedge clk); #1;
      end
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_dv_off", {31'd0, dv0},  32'd0);
    check("abort_din0",   {24'd0, din0}, 32'd0);
    check("abort_ready",  {31'd0, rdy0}, 32'd1);
    check("abort_done",   {31'd0, done0}, 32'd0);
    check("abort_succ",   {31'd0, succ0}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      check("abort_nodone", {31'd0, done0}, 32'd0);
      check("abort_idle",   {31'd0, dv0},   32'd0);
    end
    $display("abort checked");
    run(0, 32'ha1b2c3d4, 64'd0, 1'b0);

    // code_valid held high over back-to-back attempts. The safe opens only
    // during the last byte cycle, so success comes from the hit flag.
    run(0, 32'h55aa33cc, 64'd1 << 4, 1'b1);
    run(0, 32'h0f1e2d3c, 64'd1 << 4, 1'b1);
    run(0, 32'h99887766, 64'd0, 1'b0);

    // Randomised attempts.
    for (int i = 0; i < 40; i++) begin
      sel  = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 3));
      case (mode)
        0: u = 64'd0;
        1: u = 64'd1 << $urandom_range(1, 22);
        2: u = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: u = {32'd0, $urandom} << ((sel != 0) ? 11 : 5);
      endcase
      run(sel, $urandom, u, 1'b0);
    end

    unlocked = 1'b0;
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/safe_code_sender.md
Name: safe_code_sender

Overview:
- Upstream driver for the safe's byte-entry port.
- Accepts a full code word over a valid/ready handshake, then streams it MSB-first as bytes on a din/din_valid interface with optional inter-byte gaps.
- Watches the safe's unlocked flag for a bounded window after the last byte and reports a one-cycle done pulse with a pass/fail result.
- Used by brute-force and directed benches and by the top-level entry path.

Parameters:
- NBYTES, 4, number of bytes per code; code width is 8*NBYTES.
- GAP, 0, idle cycles with din_valid=0 inserted between consecutive bytes; 0 gives back-to-back bytes.
- TIMEOUT, 8, WAIT-state cycles (>=1) to observe unlocked after the last byte before declaring failure.

Ports:
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- code_in  input  8*NBYTES  code word to send; byte NBYTES-1 (MSB) goes first.
- code_valid  input  1  code_in is valid.
- code_ready  output  1  block can accept a code (IDLE only).
- din  output  8  current code byte to the safe; 0 when din_valid=0.
- din_valid  output  1  din carries a byte this cycle.
- unlocked  input  1  unlock flag from the safe.
- done  output  1  one-cycle pulse, attempt finished.
- success  output  1  result of the last attempt; valid from the done cycle until the next acceptance.

Behaviour:
- One clock. Reset is synchronous and active-high; the ports are clk and reset.
- All outputs are registered. Reset values:
  - code_ready=1 (IDLE)
  - din=0, din_valid=0, done=0, success=0
  - byte index, gap counter, timeout counter and hit flag all cleared.
- States: IDLE, SEND, GAP, WAIT, DONE.
- IDLE:
  - code_ready=1.
  - Handshake occurs when code_valid and code_ready are both sampled high at edge k. Latch code_in, clear the hit flag, clear success, go to SEND with index 0.
  - code_valid while not in IDLE is ignored; no buffering.
- SEND:
  - Exactly one cycle per byte: din_valid=1, din=code[8*(NBYTES-1-idx) +: 8].
  - First byte is presented in cycle k+1.
  - After a byte cycle: if idx==NBYTES-1, go to WAIT. Otherwise idx++, then go to GAP if GAP>0, else remain in SEND.
- GAP:
  - din_valid=0, din=0 for exactly GAP cycles, then return to SEND.
- WAIT:
  - din_valid=0.
  - Timeout counter runs from 0. Exit at the first edge where (hit flag set or unlocked=1) or the counter has reached TIMEOUT-1, i.e. at most TIMEOUT cycles in WAIT.
  - Next state is DONE; success is registered as (hit or unlocked).
- Hit flag:
  - Set by unlocked=1 sampled in any of SEND, GAP or WAIT.
  - This covers a safe that asserts unlocked coincident with the last byte.
- DONE:
  - done=1 for exactly one cycle, success valid.
  - Next cycle goes to IDLE, code_ready=1.
  - success holds its value until the next handshake clears it.
- Timing with GAP=0, NBYTES=4:
  - Handshake at edge k.
  - Bytes in cycles k+1..k+4.
  - WAIT from k+5.
  - done no earlier than k+6 and no later than k+5+TIMEOUT.
  - code_ready low from k+1 until done; back high the cycle after done.
- Reset mid-operation:
  - Any state goes to IDLE at the next edge.
  - din_valid, done and success drop to 0; the partial code is discarded.
  - No done pulse is produced for the aborted attempt.
- unlocked in IDLE or DONE is ignored.

Test Plan:
- Reset 2 cycles, then code_in=32'hbaadc0de with code_valid for 1 cycle at edge k, GAP=0 -> din=ba,ad,c0,de with din_valid=1 in cycles k+1..k+4; din=0 and din_valid=0 in cycle k+5.
- Same code; model safe asserts unlocked in cycle k+6 -> done=1, success=1 in cycle k+7; code_ready=1 in cycle k+8.
- Code 32'h12345678; unlocked never asserted, TIMEOUT=8 -> WAIT lasts 8 cycles, done=1, success=0 exactly once at cycle k+13; no extra din_valid.
- GAP=2, code 32'h01020304 -> din_valid pattern 1,0,0,1,0,0,1,0,0,1 from k+1; bytes 01,02,03,04 in order.
- reset asserted during the 3rd byte cycle -> next cycle din_valid=0, code_ready=1; no done pulse; a new code accepted afterwards sends all 4 bytes from byte 0.
- code_valid held high continuously across two attempts -> second handshake only in the cycle after done (code_ready=1); unlocked asserted on the last byte cycle alone -> success=1 via the hit flag.
